// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch-side sequencer: pcWrite selector, FSM states and the
// default $v0 code that halts the core on SYSCALL.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_BEQ  = 2'b01,
        PC_BNE  = 2'b10,
        PC_JUMP = 2'b11
    } pc_write_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [31:0] HALT_CODE_DEFAULT = 32'd10;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: syscall first, then branch/jump decode of pcWrite.
// Also reports which counters the current instruction should bump.
module next_pc_logic
    import cpu_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] HALT_CODE  = HALT_CODE_DEFAULT
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [1:0]            pcWrite,
    input  logic                  jump,
    input  logic                  syscall,
    input  logic [31:0]           syscallCode,
    input  logic                  aluEqual,
    input  logic [15:0]           branchOffset,
    input  logic [25:0]           jumpIndex,
    input  logic [ADDR_WIDTH-1:0] registerTarget,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  halt_req,
    output logic                  show_req,
    output logic                  is_branch,
    output logic                  is_taken,
    output logic                  is_jump
);

    localparam logic [ADDR_WIDTH-1:0] FOUR       = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] jump_target;

    assign pc_plus4      = pc + FOUR;
    assign branch_target = pc_plus4 + {{(ADDR_WIDTH-18){branchOffset[15]}}, branchOffset, 2'b00};
    assign jump_target   = {pc_plus4[ADDR_WIDTH-1:28], jumpIndex, 2'b00};

    always_comb begin
        next_pc   = pc_plus4;
        halt_req  = 1'b0;
        show_req  = 1'b0;
        is_branch = 1'b0;
        is_taken  = 1'b0;
        is_jump   = 1'b0;
        if (syscall) begin
            // A halting syscall keeps pc so resume restarts right after it.
            if (syscallCode == HALT_CODE) begin
                halt_req = 1'b1;
                next_pc  = pc;
            end else begin
                show_req = 1'b1;
            end
        end else begin
            case (pcWrite)
                PC_BEQ: begin
                    is_branch = 1'b1;
                    is_taken  = aluEqual;
                end
                PC_BNE: begin
                    is_branch = 1'b1;
                    is_taken  = ~aluEqual;
                end
                PC_JUMP: begin
                    is_jump = 1'b1;
                    next_pc = jump ? jump_target : (registerTarget & ALIGN_MASK);
                end
                default: next_pc = pc_plus4;
            endcase
            if (is_taken) begin
                next_pc = branch_target;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, RUN/HALT state, syscall display register and performance counters
// for the single-cycle MIPS fetch path.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [31:0]           HALT_CODE   = HALT_CODE_DEFAULT,
    parameter int                    COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic [1:0]             pcWrite,
    input  logic                   jump,
    input  logic                   syscall,
    input  logic                   aluEqual,
    input  logic [15:0]            branchOffset,
    input  logic [25:0]            jumpIndex,
    input  logic [ADDR_WIDTH-1:0]  registerTarget,
    input  logic [31:0]            syscallCode,
    input  logic [31:0]            syscallArg,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [ADDR_WIDTH-1:0]  pcPlus4,
    output logic                   halted,
    output logic [31:0]            displayValue,
    output logic                   displayValid,
    output logic [COUNT_WIDTH-1:0] cycleCount,
    output logic [COUNT_WIDTH-1:0] jumpCount,
    output logic [COUNT_WIDTH-1:0] branchCount,
    output logic [COUNT_WIDTH-1:0] takenCount
);

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_t                 state_reg;
    logic                   halted_reg;
    logic [ADDR_WIDTH-1:0]  pc_reg;
    logic [31:0]            display_value_reg;
    logic                   display_valid_reg;
    logic [COUNT_WIDTH-1:0] cycle_count_reg;
    logic [COUNT_WIDTH-1:0] jump_count_reg;
    logic [COUNT_WIDTH-1:0] branch_count_reg;
    logic [COUNT_WIDTH-1:0] taken_count_reg;

    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  next_pc;
    logic                   halt_req;
    logic                   show_req;
    logic                   is_branch;
    logic                   is_taken;
    logic                   is_jump;

    next_pc_logic #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .HALT_CODE  (HALT_CODE)
    ) u_next_pc (
        .pc             (pc_reg),
        .pcWrite        (pcWrite),
        .jump           (jump),
        .syscall        (syscall),
        .syscallCode    (syscallCode),
        .aluEqual       (aluEqual),
        .branchOffset   (branchOffset),
        .jumpIndex      (jumpIndex),
        .registerTarget (registerTarget),
        .pc_plus4       (pc_plus4),
        .next_pc        (next_pc),
        .halt_req       (halt_req),
        .show_req       (show_req),
        .is_branch      (is_branch),
        .is_taken       (is_taken),
        .is_jump        (is_jump)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_RUN;
            halted_reg        <= 1'b0;
            pc_reg            <= RESET_PC;
            display_value_reg <= '0;
            display_valid_reg <= 1'b0;
            cycle_count_reg   <= '0;
            jump_count_reg    <= '0;
            branch_count_reg  <= '0;
            taken_count_reg   <= '0;
        end else begin
            display_valid_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    pc_reg <= next_pc;
                    if (halt_req) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        cycle_count_reg <= cycle_count_reg + ONE;
                    end
                    if (show_req) begin
                        display_value_reg <= syscallArg;
                        display_valid_reg <= 1'b1;
                    end
                    if (is_jump)   jump_count_reg   <= jump_count_reg + ONE;
                    if (is_branch) branch_count_reg <= branch_count_reg + ONE;
                    if (is_taken)  taken_count_reg  <= taken_count_reg + ONE;
                end
                ST_HALT: begin
                    if (go) begin
                        pc_reg     <= pc_plus4;
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= ST_RUN;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_reg;
    assign pcPlus4      = pc_plus4;
    assign halted       = halted_reg;
    assign displayValue = display_value_reg;
    assign displayValid = display_valid_reg;
    assign cycleCount   = cycle_count_reg;
    assign jumpCount    = jump_count_reg;
    assign branchCount  = branch_count_reg;
    assign takenCount   = taken_count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized stimulus for pc_sequencer, scored every cycle against a
// behavioural model of the PC/halt/counter rules.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        go;
    logic [1:0]  pcWrite;
    logic        jump;
    logic        syscall;
    logic        aluEqual;
    logic [15:0] branchOffset;
    logic [25:0] jumpIndex;
    logic [31:0] registerTarget;
    logic [31:0] syscallCode;
    logic [31:0] syscallArg;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        halted;
    logic [31:0] displayValue;
    logic        displayValid;
    logic [31:0] cycleCount;
    logic [31:0] jumpCount;
    logic [31:0] branchCount;
    logic [31:0] takenCount;

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .go             (go),
        .pcWrite        (pcWrite),
        .jump           (jump),
        .syscall        (syscall),
        .aluEqual       (aluEqual),
        .branchOffset   (branchOffset),
        .jumpIndex      (jumpIndex),
        .registerTarget (registerTarget),
        .syscallCode    (syscallCode),
        .syscallArg     (syscallArg),
        .pc             (pc),
        .pcPlus4        (pcPlus4),
        .halted         (halted),
        .displayValue   (displayValue),
        .displayValid   (displayValid),
        .cycleCount     (cycleCount),
        .jumpCount      (jumpCount),
        .branchCount    (branchCount),
        .takenCount     (takenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int step_num     = 0;

    // Reference state
    logic [31:0] m_pc, m_disp, m_cyc, m_jmp, m_br, m_tk;
    logic        m_halted, m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (step %0d)", tag, got, exp, step_num);
        end
    endtask

    task automatic model_step();
        logic [31:0] off;
        logic        taken;
        if (rst) begin
            m_pc = 32'h0; m_halted = 1'b0; m_disp = 32'h0; m_valid = 1'b0;
            m_cyc = 0; m_jmp = 0; m_br = 0; m_tk = 0;
        end else if (m_halted) begin
            m_valid = 1'b0;
            if (go) begin
                m_pc     = m_pc + 32'd4;
                m_halted = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            if (syscall && syscallCode == 32'd10) begin
                m_halted = 1'b1;
            end else begin
                m_cyc = m_cyc + 1;
                if (syscall) begin
                    m_pc    = m_pc + 32'd4;
                    m_disp  = syscallArg;
                    m_valid = 1'b1;
                end else if (pcWrite == 2'd1 || pcWrite == 2'd2) begin
                    taken = (pcWrite == 2'd1) ? aluEqual : !aluEqual;
                    m_br  = m_br + 1;
                    off   = 32'($signed(branchOffset));
                    if (taken) begin
                        m_tk = m_tk + 1;
                        m_pc = m_pc + 32'd4 + off * 32'd4;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end else if (pcWrite == 2'd3) begin
                    m_jmp = m_jmp + 1;
                    if (jump)
                        m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jumpIndex) * 32'd4);
                    else
                        m_pc = registerTarget - (registerTarget % 32'd4);
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        step_num++;
        check("pc", pc, m_pc);
        check("pcPlus4", pcPlus4, m_pc + 32'd4);
        check("halted", 32'(halted), 32'(m_halted));
        check("displayValue", displayValue, m_disp);
        check("displayValid", 32'(displayValid), 32'(m_valid));
        check("cycleCount", cycleCount, m_cyc);
        check("jumpCount", jumpCount, m_jmp);
        check("branchCount", branchCount, m_br);
        check("takenCount", takenCount, m_tk);
        $display("[TB] step %0d rst=%0d sys=%0d pw=%0d go=%0d -> pc=%h halted=%0d cyc=%0d",
                 step_num, rst, syscall, pcWrite, go, pc, halted, cycleCount);
    endtask

    task automatic idle();
        rst = 1'b0; go = 1'b0; pcWrite = 2'd0; jump = 1'b0; syscall = 1'b0;
        aluEqual = 1'b0; branchOffset = 16'h0; jumpIndex = 26'h0;
        registerTarget = 32'h0; syscallCode = 32'h0; syscallArg = 32'h0;
    endtask

    task automatic jr_to(input logic [31:0] target);
        idle();
        pcWrite = 2'd3; jump = 1'b0; registerTarget = target;
        step();
    endtask

    initial begin
        logic [31:0] jmp_before;
        logic [31:0] frozen_cyc;
        idle();
        rst = 1'b1;
        step();
        check("reset_pc", pc, 32'h0);
        check("reset_cyc", cycleCount, 32'h0);
        idle();
        repeat (3) step();
        check("seq_pc", pc, 32'd12);
        check("seq_cyc", cycleCount, 32'd3);

        // Taken beq backward, then not-taken
        jr_to(32'h10);
        idle(); pcWrite = 2'd1; aluEqual = 1'b1; branchOffset = 16'hFFFC;
        step();
        check("beq_taken_pc", pc, 32'h4);
        idle(); pcWrite = 2'd1; aluEqual = 1'b0; branchOffset = 16'hFFFC;
        step();
        check("beq_not_taken_pc", pc, 32'h8);
        check("beq_taken_cnt", takenCount, 32'd1);

        // J keeps upper nibble of pc+4; JR aligns the register target
        jr_to(32'h3000_0000);
        idle(); pcWrite = 2'd3; jump = 1'b1; jumpIndex = 26'h40;
        step();
        check("j_pc", pc, 32'h3000_0100);
        jr_to(32'h0000_0203);
        check("jr_pc", pc, 32'h0000_0200);

        // Non-halting syscall
        idle(); syscall = 1'b1; syscallCode = 32'd1; syscallArg = 32'hABCD;
        step();
        check("sys_disp", displayValue, 32'hABCD);
        check("sys_valid", 32'(displayValid), 32'd1);
        idle();
        step();
        check("sys_valid_drop", 32'(displayValid), 32'd0);

        // Halt at 0x20, junk inputs while halted, then resume
        jr_to(32'h20);
        idle(); syscall = 1'b1; syscallCode = 32'd10;
        step();
        check("halt_pc", pc, 32'h20);
        frozen_cyc = cycleCount;
        repeat (5) begin
            idle();
            pcWrite = 2'($urandom); syscall = 1'($urandom); syscallCode = 32'd1;
            syscallArg = $urandom; registerTarget = $urandom;
            step();
        end
        check("halt_frozen_cyc", cycleCount, frozen_cyc);
        idle(); go = 1'b1;
        step();
        check("resume_pc", pc, 32'h24);

        // Syscall dominates an unconditional jump
        jmp_before = jumpCount;
        idle(); syscall = 1'b1; syscallCode = 32'd2; syscallArg = 32'h55;
        pcWrite = 2'd3; jump = 1'b1; jumpIndex = 26'h3FF_FFFF;
        step();
        check("prio_jmp_cnt", jumpCount, jmp_before);
        check("prio_pc", pc, 32'h28);

        // Reset while halted
        idle(); syscall = 1'b1; syscallCode = 32'd10;
        step();
        idle(); rst = 1'b1;
        step();
        check("rst_halt_pc", pc, 32'h0);
        check("rst_halt_halted", 32'(halted), 32'd0);
        check("rst_halt_br", branchCount, 32'd0);

        // Sequential wrap at the top of the address space
        jr_to(32'hFFFF_FFFC);
        idle();
        step();
        check("wrap_pc", pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            idle();
            rst            = ($urandom_range(0, 199) == 0);
            go             = m_halted ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            pcWrite        = 2'($urandom);
            jump           = 1'($urandom);
            aluEqual       = 1'($urandom);
            branchOffset   = 16'($urandom);
            jumpIndex      = 26'($urandom);
            registerTarget = $urandom;
            syscall        = ($urandom_range(0, 7) == 0);
            syscallCode    = ($urandom_range(0, 1) == 0) ? 32'd10 : 32'($urandom_range(0, 20));
            syscallArg     = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
